// File: rtl/trg_mon_frame_ctrl.sv
// Telemetry frame controller: snapshots the monitor block, then streams
// header, monitor words ADDR_FIRST..ADDR_LAST and a 16-bit checksum.
module trg_mon_frame_ctrl #(
  parameter logic [7:0]  ADDR_FIRST = 8'h02,
  parameter logic [7:0]  ADDR_LAST  = 8'h24,
  parameter logic [15:0] FRAME_HDR  = 16'hEB90
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tm_req_in,
  input  logic        abort_in,
  output logic        store_en_out,
  output logic        rd_out,
  output logic [7:0]  rd_addr_out,
  input  logic [15:0] mon_data_in,
  output logic [15:0] word_data_out,
  output logic        word_valid_out,
  input  logic        word_ready_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        ovr_out
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    HDR,
    RD,
    LAT,
    SEND,
    CKS,
    DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic [15:0] r_cks;
  logic        w_xfer;

  assign w_xfer = word_valid_out & word_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_addr         <= 8'h00;
      r_cks          <= 16'h0000;
      store_en_out   <= 1'b0;
      rd_out         <= 1'b0;
      rd_addr_out    <= 8'h00;
      word_data_out  <= 16'h0000;
      word_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      ovr_out        <= 1'b0;
    end else begin
      store_en_out <= 1'b0;
      rd_out       <= 1'b0;
      done_out     <= 1'b0;
      if (r_state != IDLE && tm_req_in)
        ovr_out <= 1'b1;
      // Abort wins over any pending transfer in the same cycle.
      if (r_state != IDLE && abort_in) begin
        r_state        <= IDLE;
        word_valid_out <= 1'b0;
        busy_out       <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (tm_req_in) begin
              r_state      <= STORE;
              store_en_out <= 1'b1;
              busy_out     <= 1'b1;
              ovr_out      <= 1'b0;
            end
          end
          STORE: begin
            r_addr         <= ADDR_FIRST;
            r_cks          <= 16'h0000;
            word_data_out  <= FRAME_HDR;
            word_valid_out <= 1'b1;
            r_state        <= HDR;
          end
          HDR: begin
            if (w_xfer) begin
              word_valid_out <= 1'b0;
              rd_out         <= 1'b1;
              rd_addr_out    <= r_addr;
              r_state        <= RD;
            end
          end
          RD: begin
            r_state <= LAT;
          end
          LAT: begin
            word_data_out  <= mon_data_in;
            r_cks          <= r_cks + mon_data_in;
            word_valid_out <= 1'b1;
            r_state        <= SEND;
          end
          SEND: begin
            if (w_xfer) begin
              if (r_addr >= ADDR_LAST) begin
                word_data_out <= r_cks;
                r_state       <= CKS;
              end else begin
                word_valid_out <= 1'b0;
                r_addr         <= r_addr + 8'd1;
                rd_out         <= 1'b1;
                rd_addr_out    <= r_addr + 8'd1;
                r_state        <= RD;
              end
            end
          end
          CKS: begin
            if (w_xfer) begin
              word_valid_out <= 1'b0;
              done_out       <= 1'b1;
              r_state        <= DONE;
            end
          end
          DONE: begin
            busy_out <= 1'b0;
            r_state  <= IDLE;
          end
          default: begin
            word_valid_out <= 1'b0;
            busy_out       <= 1'b0;
            r_state        <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trg_mon_frame_ctrl.sv
// Directed bench for trg_mon_frame_ctrl with a registered monitor model
// (data = address) and a word collector sampled on the falling edge.
module tb_trg_mon_frame_ctrl;

  localparam int NW = 37;
  localparam logic [15:0] EXP_CKS = 16'h0299;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] mon = 16'h0000;

  logic        store_en_out;
  logic        rd_out;
  logic [7:0]  rd_addr_out;
  logic [15:0] word_data_out;
  logic        word_valid_out;
  logic        busy_out;
  logic        done_out;
  logic        ovr_out;

  trg_mon_frame_ctrl dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .tm_req_in     (req),
    .abort_in      (abort),
    .store_en_out  (store_en_out),
    .rd_out        (rd_out),
    .rd_addr_out   (rd_addr_out),
    .mon_data_in   (mon),
    .word_data_out (word_data_out),
    .word_valid_out(word_valid_out),
    .word_ready_in (ready),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .ovr_out       (ovr_out)
  );

  // Monitor block: data valid one cycle after the read strobe.
  always @(posedge clk)
    mon <= rd_out ? {8'h00, rd_addr_out} : 16'hBAD0;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int store_cnt, done_cnt, rd_cnt;
  int viol_rdst, viol_cap, viol_stab;
  int rdy_mode, rdy_ph;
  int nerr;
  bit ok;
  bit lat_pend, rd_prev;
  logic        p_valid, p_ready;
  logic [15:0] p_data, cap_exp;
  logic [15:0] words[$];
  logic [15:0] exp_words[NW];

  task automatic step();
    bit kill;
    @(negedge clk);
    if (rdy_mode == 1) begin
      ready = (rdy_ph % 3 == 2);
      rdy_ph++;
    end else begin
      ready = 1'b1;
    end
    kill = abort || rst;
    if (store_en_out === 1'b1) store_cnt++;
    if (done_out === 1'b1) done_cnt++;
    if (rd_out === 1'b1) rd_cnt++;
    if (rd_out === 1'b1 && store_en_out === 1'b1) viol_rdst++;
    if (lat_pend && !kill &&
        !(word_valid_out === 1'b1 && word_data_out === cap_exp))
      viol_cap++;
    if (p_valid === 1'b1 && p_ready === 1'b0 && !kill &&
        !(word_valid_out === 1'b1 && word_data_out === p_data))
      viol_stab++;
    lat_pend = rd_prev && !kill;
    if (rd_prev) cap_exp = mon;
    rd_prev = (rd_out === 1'b1);
    if (word_valid_out === 1'b1 && ready)
      words.push_back(word_data_out);
    p_valid = word_valid_out;
    p_ready = ready;
    p_data  = word_data_out;
  endtask

  task automatic clear_stats();
    store_cnt = 0;
    done_cnt  = 0;
    rd_cnt    = 0;
    words.delete();
  endtask

  task automatic pulse_req();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic run_to_done(input int max);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (done_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_out); else pass_cnt++;
    chk_cnt++; if (word_valid_out !== 1'b0) $display("FAIL rst_valid got %b want 0", word_valid_out); else pass_cnt++;
    chk_cnt++; if (word_data_out !== 16'h0000) $display("FAIL rst_data got %h want 0000", word_data_out); else pass_cnt++;
    chk_cnt++; if (rd_addr_out !== 8'h00) $display("FAIL rst_addr got %h want 00", rd_addr_out); else pass_cnt++;
    chk_cnt++; if (store_en_out !== 1'b0) $display("FAIL rst_store got %b want 0", store_en_out); else pass_cnt++;
    chk_cnt++; if (rd_out !== 1'b0) $display("FAIL rst_rd got %b want 0", rd_out); else pass_cnt++;
    chk_cnt++; if (done_out !== 1'b0) $display("FAIL rst_done got %b want 0", done_out); else pass_cnt++;
    chk_cnt++; if (ovr_out !== 1'b0) $display("FAIL rst_ovr got %b want 0", ovr_out); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL abort_idle_busy got %b want 0", busy_out); else pass_cnt++;
    chk_cnt++; if (word_valid_out !== 1'b0) $display("FAIL abort_idle_valid got %b want 0", word_valid_out); else pass_cnt++;
  endtask

  task automatic test_frame();
    rdy_mode = 0;
    clear_stats();
    pulse_req();
    chk_cnt++; if (store_en_out !== 1'b1) $display("FAIL frame_store got %b want 1", store_en_out); else pass_cnt++;
    run_to_done(400);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL frame_timeout got %b want 1", ok); else pass_cnt++;
    nerr = 0;
    foreach (exp_words[i]) if (i >= words.size() || words[i] !== exp_words[i]) nerr++;
    chk_cnt++; if (words.size() !== NW) $display("FAIL frame_len got %0d want %0d", words.size(), NW); else pass_cnt++;
    chk_cnt++; if (nerr !== 0) $display("FAIL frame_words got %0d bad want 0", nerr); else pass_cnt++;
    chk_cnt++; if (store_cnt !== 1) $display("FAIL frame_store_cnt got %0d want 1", store_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL frame_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (rd_cnt !== 35) $display("FAIL frame_rd_cnt got %0d want 35", rd_cnt); else pass_cnt++;
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL frame_busy_end got %b want 0", busy_out); else pass_cnt++;
    chk_cnt++; if (rd_addr_out !== 8'h24) $display("FAIL frame_addr_hold got %h want 24", rd_addr_out); else pass_cnt++;
  endtask

  task automatic test_stall();
    rdy_mode = 1;
    rdy_ph   = 0;
    clear_stats();
    pulse_req();
    run_to_done(1000);
    rdy_mode = 0;
    chk_cnt++; if (ok !== 1'b1) $display("FAIL stall_timeout got %b want 1", ok); else pass_cnt++;
    nerr = 0;
    foreach (exp_words[i]) if (i >= words.size() || words[i] !== exp_words[i]) nerr++;
    chk_cnt++; if (words.size() !== NW) $display("FAIL stall_len got %0d want %0d", words.size(), NW); else pass_cnt++;
    chk_cnt++; if (nerr !== 0) $display("FAIL stall_words got %0d bad want 0", nerr); else pass_cnt++;
    chk_cnt++; if (viol_stab !== 0) $display("FAIL stall_stable got %0d want 0", viol_stab); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL stall_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_ovr();
    rdy_mode = 0;
    clear_stats();
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rd_out === 1'b1 && rd_addr_out === 8'h10) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++; if (ok !== 1'b1) $display("FAIL ovr_find_rd got %b want 1", ok); else pass_cnt++;
    req = 1'b1;
    step();
    req = 1'b0;
    chk_cnt++; if (ovr_out !== 1'b1) $display("FAIL ovr_set got %b want 1", ovr_out); else pass_cnt++;
    run_to_done(400);
    nerr = 0;
    foreach (exp_words[i]) if (i >= words.size() || words[i] !== exp_words[i]) nerr++;
    chk_cnt++; if (words.size() !== NW || nerr !== 0) $display("FAIL ovr_frame got %0d words %0d bad want %0d words 0 bad", words.size(), nerr, NW); else pass_cnt++;
    chk_cnt++; if (store_cnt !== 1) $display("FAIL ovr_store_cnt got %0d want 1", store_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL ovr_done_cnt got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (ovr_out !== 1'b1) $display("FAIL ovr_sticky got %b want 1", ovr_out); else pass_cnt++;
    req   = 1'b1;
    abort = 1'b1;
    step();
    req   = 1'b0;
    abort = 1'b0;
    chk_cnt++; if (busy_out !== 1'b1) $display("FAIL ovr_req_abort_accept got %b want 1", busy_out); else pass_cnt++;
    chk_cnt++; if (ovr_out !== 1'b0) $display("FAIL ovr_clear got %b want 0", ovr_out); else pass_cnt++;
    run_to_done(400);
  endtask

  task automatic test_abort();
    rdy_mode = 0;
    clear_stats();
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (word_valid_out === 1'b1 && word_data_out === 16'h000A) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++; if (ok !== 1'b1) $display("FAIL abort_find_send got %b want 1", ok); else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_out); else pass_cnt++;
    chk_cnt++; if (word_valid_out !== 1'b0) $display("FAIL abort_valid got %b want 0", word_valid_out); else pass_cnt++;
    clear_stats();
    for (int i = 0; i < 40; i++) step();
    chk_cnt++; if (rd_cnt !== 0) $display("FAIL abort_rd_after got %0d want 0", rd_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 0) $display("FAIL abort_done got %0d want 0", done_cnt); else pass_cnt++;
    clear_stats();
    pulse_req();
    run_to_done(400);
    nerr = 0;
    foreach (exp_words[i]) if (i >= words.size() || words[i] !== exp_words[i]) nerr++;
    chk_cnt++; if (words.size() !== NW || nerr !== 0) $display("FAIL abort_refrm got %0d words %0d bad want %0d words 0 bad", words.size(), nerr, NW); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    clear_stats();
    pulse_req();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (word_valid_out === 1'b1 && words.size() == NW) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++; if (ok !== 1'b1) $display("FAIL rmid_find_cks got %b want 1", ok); else pass_cnt++;
    chk_cnt++; if (word_data_out !== EXP_CKS) $display("FAIL rmid_cks got %h want %h", word_data_out, EXP_CKS); else pass_cnt++;
    done_cnt = 0;
    rst = 1'b1;
    step();
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy_out); else pass_cnt++;
    chk_cnt++; if (word_valid_out !== 1'b0) $display("FAIL rmid_valid got %b want 0", word_valid_out); else pass_cnt++;
    chk_cnt++; if (word_data_out !== 16'h0000) $display("FAIL rmid_data got %h want 0000", word_data_out); else pass_cnt++;
    chk_cnt++; if (rd_addr_out !== 8'h00) $display("FAIL rmid_addr got %h want 00", rd_addr_out); else pass_cnt++;
    chk_cnt++; if ({store_en_out, rd_out, ovr_out} !== 3'b000) $display("FAIL rmid_strobes got %b want 000", {store_en_out, rd_out, ovr_out}); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_cnt++; if (done_cnt !== 0) $display("FAIL rmid_done got %0d want 0", done_cnt); else pass_cnt++;
  endtask

  task automatic test_invariants();
    chk_cnt++; if (viol_rdst !== 0) $display("FAIL inv_rd_store got %0d want 0", viol_rdst); else pass_cnt++;
    chk_cnt++; if (viol_cap !== 0) $display("FAIL inv_capture got %0d want 0", viol_cap); else pass_cnt++;
    chk_cnt++; if (viol_stab !== 0) $display("FAIL inv_stable got %0d want 0", viol_stab); else pass_cnt++;
  endtask

  initial begin
    exp_words[0] = 16'hEB90;
    for (int i = 0; i < NW - 2; i++) exp_words[i + 1] = 16'(i + 2);
    exp_words[NW - 1] = EXP_CKS;
    test_reset();
    test_abort_idle();
    test_frame();
    test_stall();
    test_ovr();
    test_abort();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
